// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bus bundle: command handshake, pad enables/inputs and
// transfer status. The slave modport is the transmitter; the master modport is
// the surrounding logic (command source plus pad wiring).
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_valid, tx_data, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_valid, tx_data, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the device clock, issues the
// request-to-send start bit, shifts out data + odd parity + stop on the
// device's clock falling edges, then samples the device ACK bit. Pad enables
// are active-high pull-low requests; tristates live at the top level.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_XFER,
        S_ACK
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [8:0]       r_shift;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_done;
    logic             r_ack_err;
    logic             r_timeout_err;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_s3;
    logic             r_dat_s1;
    logic             r_dat_s2;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_idx_nxt;
    logic [8:0]       w_shift_nxt;
    logic             w_clk_oe_nxt;
    logic             w_data_oe_nxt;
    logic             w_done_nxt;
    logic             w_ack_err_nxt;
    logic             w_timeout_err_nxt;
    logic             w_fe;

    // Two-flop synchronisers for both pads, plus a delayed copy of the clock
    // for falling-edge detection. Idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= bus.ps2_data_i;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fe = r_clk_s3 & ~r_clk_s2;

    // State, counters, shift register, registered pad enables and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_clk_oe      <= 1'b0;
            r_data_oe     <= 1'b0;
            r_done        <= 1'b0;
            r_ack_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_clk_oe      <= w_clk_oe_nxt;
            r_data_oe     <= w_data_oe_nxt;
            r_done        <= w_done_nxt;
            r_ack_err     <= w_ack_err_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    // Next-state logic. The cycle counter serves the inhibit period and then
    // the edge timeout; in XFER/ACK it holds the number of cycles since the
    // last edge (or REQ), counting that cycle as 1, so the timeout pulse lands
    // exactly TIMEOUT_CYCLES after it. A falling edge always beats the timeout.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_idx_nxt         = r_idx;
        w_shift_nxt       = r_shift;
        w_clk_oe_nxt      = r_clk_oe;
        w_data_oe_nxt     = r_data_oe;
        w_done_nxt        = 1'b0;
        w_ack_err_nxt     = 1'b0;
        w_timeout_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (bus.tx_valid) begin
                    w_state_nxt  = S_INHIBIT;
                    w_cnt_nxt    = '0;
                    w_shift_nxt  = {~^bus.tx_data, bus.tx_data};
                    w_clk_oe_nxt = 1'b1;
                end
            end

            S_INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_state_nxt   = S_REQ;
                    w_cnt_nxt     = '0;
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_REQ: begin
                w_state_nxt = S_XFER;
                w_cnt_nxt   = CNT_ONE;
                w_idx_nxt   = '0;
            end

            S_XFER: begin
                if (w_fe) begin
                    w_cnt_nxt = CNT_ONE;
                    w_idx_nxt = r_idx + 4'd1;
                    if (r_idx == 4'd9) begin
                        // Tenth edge: stop bit, line released, await ACK.
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = S_ACK;
                    end else begin
                        // Edges 1..9: data LSB first, then parity.
                        w_data_oe_nxt = ~r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[8:1]};
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt       = S_IDLE;
                    w_clk_oe_nxt      = 1'b0;
                    w_data_oe_nxt     = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_ACK: begin
                if (w_fe) begin
                    w_state_nxt   = S_IDLE;
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b0;
                    w_done_nxt    = ~r_dat_s2;
                    w_ack_err_nxt = r_dat_s2;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt       = S_IDLE;
                    w_clk_oe_nxt      = 1'b0;
                    w_data_oe_nxt     = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
            end
        endcase
    end

    assign bus.tx_ready    = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.ps2_clk_oe  = r_clk_oe;
    assign bus.ps2_data_oe = r_data_oe;
    assign bus.done        = r_done;
    assign bus.ack_err     = r_ack_err;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a behavioural PS/2 device that
// clocks the frame, captures the data line and optionally ACKs.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 300;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    int   m_done = 0;
    int   m_ack = 0;
    int   m_to = 0;
    logic m_rel = 1'b0;
    logic m_rdy = 1'b0;
    logic m_prev_pulse = 1'b0;
    logic m_busy_after = 1'b0;

    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    // Open-drain pads: low if either side pulls low.
    assign bus.ps2_clk_i  = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_data_i = dev_data & ~bus.ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pulse counters and snapshots taken in the pulse cycle and the one after.
    always @(negedge clk) begin
        if (bus.done)        m_done <= m_done + 1;
        if (bus.ack_err)     m_ack  <= m_ack + 1;
        if (bus.timeout_err) m_to   <= m_to + 1;
        if (bus.done | bus.ack_err | bus.timeout_err) begin
            m_rel <= ~bus.ps2_clk_oe & ~bus.ps2_data_oe;
            m_rdy <= bus.tx_ready;
        end
        if (m_prev_pulse) m_busy_after <= bus.busy;
        m_prev_pulse <= bus.done | bus.ack_err | bus.timeout_err;
    end

    // Called at the first negedge after acceptance; returns at the REQ cycle.
    task automatic wait_req(output int inh_len, output logic dat_in_inh, output logic req_dat);
        inh_len = 0;
        dat_in_inh = 1'b0;
        req_dat = 1'b0;
        for (int i = 0; i < INH + 20; i++) begin
            if (bus.ps2_clk_oe) begin
                inh_len++;
                dat_in_inh = dat_in_inh | bus.ps2_data_oe;
            end else if (inh_len > 0) begin
                req_dat = bus.ps2_data_oe;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Device side: nclk clock pulses (10 low / 10 high). line[n] is the data
    // line at the end of the low phase of pulse n; oe2/oe3 are the host data
    // enable two and three cycles after the pad fell.
    task automatic dev_frame(input int nclk, input logic ack_low,
                             output logic [11:0] line, output logic [11:0] oe2,
                             output logic [11:0] oe3, output logic start_line);
        line = '0;
        oe2 = '0;
        oe3 = '0;
        repeat (5) @(negedge clk);
        start_line = bus.ps2_data_i;
        for (int n = 1; n <= nclk; n++) begin
            if (n == 11 && ack_low) begin
                dev_data = 1'b0;
                repeat (3) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (2) @(negedge clk);
            oe2[n] = bus.ps2_data_oe;
            @(negedge clk);
            oe3[n] = bus.ps2_data_oe;
            repeat (7) @(negedge clk);
            line[n] = bus.ps2_data_i;
            dev_clk = 1'b1;
            dev_data = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe,
             bus.done, bus.ack_err, bus.timeout_err} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 1000000",
                     {bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe,
                      bus.done, bus.ack_err, bus.timeout_err});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe} !== 4'b1000) begin
            n_err++;
            $display("FAIL idle_after_reset got %b want 1000",
                     {bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe});
        end
    endtask

    // Full transfer of one byte; ack_low=1 means the device ACKs.
    task automatic test_send(input logic [7:0] b, input logic exp_par, input logic ack_low);
        int inh_len;
        logic dat_in_inh, req_dat, start_line;
        logic [11:0] line, oe2, oe3;
        int d0, a0, t0;
        d0 = m_done; a0 = m_ack; t0 = m_to;
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_req(inh_len, dat_in_inh, req_dat);
        n_vec++;
        if (inh_len !== INH) begin
            n_err++;
            $display("FAIL inhibit_len[%h] got %0d want %0d", b, inh_len, INH);
        end
        n_vec++;
        if ({dat_in_inh, req_dat} !== 2'b01) begin
            n_err++;
            $display("FAIL req_data[%h] got inh/req %b want 01", b, {dat_in_inh, req_dat});
        end
        dev_frame(11, ack_low, line, oe2, oe3, start_line);
        n_vec++;
        if (start_line !== 1'b0) begin
            n_err++;
            $display("FAIL start_bit[%h] got %b want 0", b, start_line);
        end
        for (int i = 1; i <= 8; i++) begin
            n_vec++;
            if (line[i] !== b[i-1]) begin
                n_err++;
                $display("FAIL data_bit%0d[%h] got %b want %b", i - 1, b, line[i], b[i-1]);
            end
        end
        n_vec++;
        if (line[9] !== exp_par) begin
            n_err++;
            $display("FAIL parity[%h] got %b want %b", b, line[9], exp_par);
        end
        n_vec++;
        if (line[10] !== 1'b1) begin
            n_err++;
            $display("FAIL stop_bit[%h] got %b want 1", b, line[10]);
        end
        // Start bit held until fe1 is seen; new bit drives the cycle after.
        n_vec++;
        if ({oe2[1], oe3[1]} !== {1'b1, ~b[0]}) begin
            n_err++;
            $display("FAIL fe1_latency[%h] got %b want %b", b, {oe2[1], oe3[1]}, {1'b1, ~b[0]});
        end
        n_vec++;
        if ({m_done - d0, m_ack - a0, m_to - t0} !== {32'(ack_low ? 1 : 0), 32'(ack_low ? 0 : 1), 32'd0}) begin
            n_err++;
            $display("FAIL pulses[%h] got done=%0d ack_err=%0d to=%0d want ack_low=%b",
                     b, m_done - d0, m_ack - a0, m_to - t0, ack_low);
        end
        n_vec++;
        if ({m_rel, m_rdy, m_busy_after, bus.busy} !== 4'b1100) begin
            n_err++;
            $display("FAIL end_state[%h] got rel/rdy/busy_after/busy %b want 1100",
                     b, {m_rel, m_rdy, m_busy_after, bus.busy});
        end
    endtask

    task automatic test_timeout_req();
        int inh_len, k;
        logic dat_in_inh, req_dat, seen, rel, rdy;
        int d0;
        d0 = m_done;
        @(negedge clk);
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_req(inh_len, dat_in_inh, req_dat);
        k = 0; seen = 1'b0; rel = 1'b0; rdy = 1'b0;
        while (k < TO + 20) begin
            @(negedge clk);
            k++;
            if (bus.timeout_err) begin
                seen = 1'b1;
                rel = ~bus.ps2_data_oe & ~bus.ps2_clk_oe;
                rdy = bus.tx_ready;
                break;
            end
        end
        n_vec++;
        if (!seen || k !== TO) begin
            n_err++;
            $display("FAIL timeout_after_req got seen=%b cycles=%0d want %0d", seen, k, TO);
        end
        n_vec++;
        if ({rel, rdy, m_done == d0} !== 3'b111) begin
            n_err++;
            $display("FAIL timeout_req_release got rel/rdy/nodone %b want 111", {rel, rdy, m_done == d0});
        end
        @(negedge clk);
        n_vec++;
        if (bus.timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse_width got %b want 0", bus.timeout_err);
        end
    endtask

    // Device stalls after fe5; pad falls at k=0, edge detected at k=2.
    task automatic test_timeout_fe5();
        int inh_len, k;
        logic dat_in_inh, req_dat, start_line, seen, rel, pre_oe;
        logic [11:0] line, oe2, oe3;
        @(negedge clk);
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_req(inh_len, dat_in_inh, req_dat);
        dev_frame(4, 1'b0, line, oe2, oe3, start_line);
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        k = 0; seen = 1'b0; rel = 1'b0; pre_oe = 1'b0;
        while (k < TO + 30) begin
            @(negedge clk);
            k++;
            if (k == 10) begin
                dev_clk = 1'b1;
                pre_oe = bus.ps2_data_oe;
            end
            if (bus.timeout_err) begin
                seen = 1'b1;
                rel = ~bus.ps2_data_oe & ~bus.ps2_clk_oe;
                break;
            end
        end
        n_vec++;
        if (!seen || k !== TO + 2) begin
            n_err++;
            $display("FAIL timeout_after_fe5 got seen=%b cycles=%0d want %0d", seen, k, TO + 2);
        end
        n_vec++;
        if ({pre_oe, rel} !== 2'b11) begin
            n_err++;
            $display("FAIL timeout_fe5_release got pre_oe/rel %b want 11", {pre_oe, rel});
        end
    endtask

    task automatic test_reset_mid();
        int inh_len, d0, a0, t0;
        logic dat_in_inh, req_dat, start_line;
        logic [11:0] line, oe2, oe3;
        @(negedge clk);
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_req(inh_len, dat_in_inh, req_dat);
        dev_frame(4, 1'b0, line, oe2, oe3, start_line);
        d0 = m_done; a0 = m_ack; t0 = m_to;
        @(negedge clk);
        n_vec++;
        if (bus.ps2_data_oe !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_data_oe got %b want 1", bus.ps2_data_oe);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.tx_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL async_reset_release got clk_oe/data_oe/busy/ready %b want 0001",
                     {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.tx_ready});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if ({m_done - d0, m_ack - a0, m_to - t0} !== {32'd0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_no_pulse got done=%0d ack_err=%0d to=%0d want 0",
                     m_done - d0, m_ack - a0, m_to - t0);
        end
        test_send(8'hF4, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int inh_len, d0;
        logic dat_in_inh, req_dat, start_line;
        logic [11:0] line, oe2, oe3;
        logic [7:0] got;
        d0 = m_done;
        @(negedge clk);
        bus.tx_data = 8'hA5;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'h3C;
        wait_req(inh_len, dat_in_inh, req_dat);
        dev_frame(11, 1'b1, line, oe2, oe3, start_line);
        bus.tx_valid = 1'b0;
        got = line[8:1];
        n_vec++;
        if ({got, line[9]} !== {8'hA5, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_first got %h/%b want a5/1", got, line[9]);
        end
        n_vec++;
        if ({m_rdy, m_busy_after, m_done - d0} !== {1'b1, 1'b1, 32'd1}) begin
            n_err++;
            $display("FAIL b2b_accept got rdy=%b busy_after=%b done=%0d want 1 1 1",
                     m_rdy, m_busy_after, m_done - d0);
        end
        wait_req(inh_len, dat_in_inh, req_dat);
        n_vec++;
        if (req_dat !== 1'b1 || inh_len == 0) begin
            n_err++;
            $display("FAIL b2b_req got req=%b inh_len=%0d want 1 and >0", req_dat, inh_len);
        end
        dev_frame(11, 1'b1, line, oe2, oe3, start_line);
        got = line[8:1];
        n_vec++;
        if ({got, line[9], m_done - d0} !== {8'h3C, 1'b1, 32'd2}) begin
            n_err++;
            $display("FAIL b2b_second got %h/%b done=%0d want 3c/1 2", got, line[9], m_done - d0);
        end
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        test_reset();
        test_send(8'hED, 1'b1, 1'b1);
        test_send(8'h01, 1'b0, 1'b1);
        test_send(8'hFF, 1'b1, 1'b1);
        test_send(8'h55, 1'b1, 1'b0);
        test_timeout_req();
        test_timeout_fe5();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the other direction of the keyboard link currently served by the PS/2 receiver.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) using the standard request-to-send sequence, then checks the device ACK bit.
- Drives the open-drain PS2_CLK/PS2_DATA pads through active-high pull-low enables; the top level builds the tristates.
- Asserts busy so the receiver ignores bus activity during its own transmission.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2 clock is held low before the start bit (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, max clk cycles allowed between consecutive device clock falling edges, or from request to first edge (15 ms).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-low
- tx_valid  in  1  command byte offered
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid && tx_ready on a rising clk edge
- ps2_clk_i  in  1  PS2_CLK pad input (asynchronous)
- ps2_data_i  in  1  PS2_DATA pad input (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release
- ps2_data_oe  out  1  1 = pull PS2_DATA low, 0 = release
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: byte sent and ACK received
- ack_err  out  1  one-cycle pulse: ACK bit sampled high
- timeout_err  out  1  one-cycle pulse: device clock timeout

Behaviour:
- Reset (rst low, asynchronous): state IDLE; tx_ready=1; busy=0; ps2_clk_oe=0; ps2_data_oe=0; done, ack_err and timeout_err all 0; counters cleared; shift register 0.
- Synchronisers: ps2_clk_i and ps2_data_i each pass through two flops. A falling edge (fe) is synchronised previous=1 and current=0, giving a 3-cycle latency from the pad.
- Accept: on handshake, latch {parity, tx_data}, where parity = ~^tx_data (odd). Go to INHIBIT. tx_data is don't-care after acceptance.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, counting from the cycle after acceptance.
- REQ (one cycle): ps2_data_oe=1 (start bit 0), ps2_clk_oe=0. Clear the timeout counter and the bit index. Go to XFER.
- XFER:
  - fe 1..8: ps2_data_oe = ~data bit[idx], LSB first.
  - fe 9: ps2_data_oe = ~parity.
  - fe 10: ps2_data_oe=0 (stop bit; line released).
  - Go to ACK after fe 10.
  - Each output change takes effect the cycle after fe is detected.
- ACK: on fe 11, sample the synchronised data.
  - 0: pulse done, go to IDLE.
  - 1: pulse ack_err, go to IDLE.
- Timeout: the counter increments each cycle in XFER/ACK and clears on each fe. On reaching TIMEOUT_CYCLES:
  - release both lines that same cycle;
  - pulse timeout_err;
  - go to IDLE.
  - Timeout and ACK are exclusive: fe wins if both happen in the same cycle.
- Pulses (done, ack_err, timeout_err) last exactly one cycle. They are asserted in the cycle the state returns to IDLE, so tx_ready=1 in that same cycle.
- tx_valid while busy is ignored. A new byte may be accepted the cycle after a done/err pulse.
- Device clock edges seen in IDLE or INHIBIT are ignored.
- ps2_clk_oe and ps2_data_oe are never driven in IDLE.
- Reset mid-transfer releases both lines immediately (asynchronously) and discards the byte with no pulse.

Test Plan:
- Send 0xED with a device model ACKing -> clock low exactly 10000 cycles; then data low; data bits on fe1..8 = 1,0,1,1,0,1,1,1; parity 1; stop released; done pulse 1 cycle; busy low after.
- Send 0x01 -> parity bit 0 on fe9; send 0xFF -> parity bit 1; both end in done.
- Device leaves data high at the ACK clock -> ack_err pulse, done stays 0, lines released, tx_ready=1.
- No device clocks after REQ -> timeout_err exactly 1500000 cycles after REQ, data released. Also stall after fe5 -> timeout 1500000 cycles after fe5.
- rst low after fe4 -> ps2_clk_oe and ps2_data_oe 0 with no clk edge; no pulses; after release, a new 0xF4 completes with done.
- tx_valid held high through a transfer with a changing tx_data -> only the first byte is transmitted; the second is accepted the cycle after done.
